dsp_mac_sequencer: RTL and testbench

- Sequences one DSP48A1-style multiply-accumulate slice to compute a length-N dot product, sum(a[i]*b[i]), from a valid/ready operand stream.
- Drives the slice's operand, OPMODE, clock-enable and P-reset controls.
- Tracks the slice pipeline latency and captures the final P value into a result register with its own valid/ready handshake.
- Sits between the operand-fetch logic and the arithmetic slice.

---
 rtl/dsp_mac_sequencer.sv | 141 ++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1-style MAC slice through a length-N dot product and presents
// the final P value on a valid/ready result port.
module dsp_mac_sequencer #(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned OPM_DLY  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      a_in,
  input  logic [17:0]      b_in,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rstp,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data
);

  localparam logic [7:0] OpmFirst  = 8'h01;
  localparam logic [7:0] OpmAcc    = 8'h09;
  localparam logic [7:0] OpmHold   = 8'h08;
  localparam logic [3:0] DrainInit = 4'(PIPE_LAT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StHold} state_e;

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      remaining_q, remaining_d;
  logic [3:0]            drain_cnt_q, drain_cnt_d;
  logic                  first_q, first_d;
  logic [17:0]           dsp_a_q, dsp_a_d;
  logic [17:0]           dsp_b_q, dsp_b_d;
  logic [OPM_DLY:0][7:0] opm_sr_q, opm_sr_d;
  logic [47:0]           res_data_q, res_data_d;
  logic [7:0]            tag;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drain_cnt_d = drain_cnt_q;
    first_d     = first_q;
    dsp_a_d     = dsp_a_q;
    dsp_b_d     = dsp_b_q;
    opm_sr_d    = opm_sr_q;
    res_data_d  = res_data_q;
    tag         = OpmHold;
    busy        = (state_q != StIdle);
    in_ready    = 1'b0;
    dsp_ce      = 1'b0;
    dsp_rstp    = 1'b0;
    res_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        dsp_rstp = 1'b1;
        if (start) begin
          if (len != '0) begin
            remaining_d = len;
            first_d     = 1'b1;
            state_d     = StRun;
          end else begin
            res_data_d = '0;
            state_d    = StHold;
          end
        end
      end
      StRun: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dsp_ce      = 1'b1;
          dsp_a_d     = a_in;
          dsp_b_d     = b_in;
          tag         = first_q ? OpmFirst : OpmAcc;
          first_d     = 1'b0;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            drain_cnt_d = DrainInit;
            state_d     = StDrain;
          end
        end
      end
      StDrain: begin
        // Bubbles carry X=0, Z=P so the accumulated P survives the flush.
        dsp_ce      = 1'b1;
        drain_cnt_d = drain_cnt_q - 4'd1;
        if (drain_cnt_q == 4'd0) begin
          drain_cnt_d = '0;
          res_data_d  = dsp_p;
          state_d     = StHold;
        end
      end
      StHold: begin
        res_valid = 1'b1;
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // The last stage is the registered OPMODE output; it advances with the slice.
    if (dsp_ce) begin
      opm_sr_d[0] = tag;
      for (int i = 1; i <= int'(OPM_DLY); i++) opm_sr_d[i] = opm_sr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      drain_cnt_q <= '0;
      first_q     <= 1'b0;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      opm_sr_q    <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      drain_cnt_q <= drain_cnt_d;
      first_q     <= first_d;
      dsp_a_q     <= dsp_a_d;
      dsp_b_q     <= dsp_b_d;
      opm_sr_q    <= opm_sr_d;
      res_data_q  <= res_data_d;
    end
  end

  assign dsp_a      = dsp_a_q;
  assign dsp_b      = dsp_b_q;
  assign dsp_opmode = opm_sr_q[OPM_DLY];
  assign res_data   = res_data_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural MAC slice model, table vectors, corner
// sequences and randomized jobs checked against a plain sum-of-products model.
module tb_dsp_mac_sequencer;

  localparam int unsigned LEN_W    = 8;
  localparam int unsigned PIPE_LAT = 4;
  localparam int unsigned OPM_DLY  = 1;
  localparam int PHB = PIPE_LAT - 2;
  localparam int OHB = PIPE_LAT - 2 - OPM_DLY;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [17:0]      a_in = '0;
  logic [17:0]      b_in = '0;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce;
  logic             dsp_rstp;
  logic [47:0]      dsp_p;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [47:0]      res_data;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(
    .LEN_W   (LEN_W),
    .PIPE_LAT(PIPE_LAT),
    .OPM_DLY (OPM_DLY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_opmode(dsp_opmode),
    .dsp_ce    (dsp_ce),
    .dsp_rstp  (dsp_rstp),
    .dsp_p     (dsp_p),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  // Slice model: a product sampled at an enabled edge reaches P PIPE_LAT-2 enabled edges
  // later, combined with the OPMODE sampled OPM_DLY edges after that product.
  logic signed [47:0] ph [16] = '{default: '0};
  logic [7:0]         oh [16] = '{default: '0};
  logic signed [47:0] slice_p = '0;
  logic signed [47:0] m_sel = '0;
  logic [7:0]         o_sel = '0;
  int                 ce_total = 0;
  logic [7:0]         opm_seen [$];

  assign dsp_p = slice_p;

  always @(posedge clk) begin
    if (dsp_ce) begin
      for (int i = 15; i > 0; i--) begin
        ph[i] = ph[i-1];
        oh[i] = oh[i-1];
      end
      ph[0] = 48'($signed(dsp_a) * $signed(dsp_b));
      oh[0] = dsp_opmode;
      m_sel = ph[PHB];
      o_sel = oh[OHB];
      ce_total <= ce_total + 1;
      if (dsp_opmode != 8'h00 && dsp_opmode != 8'h08) opm_seen.push_back(dsp_opmode);
    end
    if (dsp_rstp) slice_p <= '0;
    else if (dsp_ce) begin
      case (o_sel)
        8'h01:   slice_p <= m_sel;
        8'h09:   slice_p <= slice_p + m_sel;
        8'h08:   slice_p <= slice_p;
        default: slice_p <= '0;
      endcase
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  logic [17:0] qa [$];
  logic [17:0] qb [$];

  function automatic logic [47:0] ref_dot();
    longint acc = 0;
    for (int i = 0; i < qa.size(); i++)
      acc += longint'($signed(qa[i])) * longint'($signed(qb[i]));
    return acc[47:0];
  endfunction

  // mode: 0 back-to-back, 1 valid on alternate cycles, 2 random gaps
  task automatic run_job(input int n, input int mode, input int rdy_dly, input bit poke,
                         input logic [47:0] exp, input string tag);
    int idx, cyc, lat, ce0, o0, n01, n09;
    bit drive;
    ce0 = ce_total;
    o0  = opm_seen.size();
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(n);
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 4 * n + 100) begin
      @(negedge clk);
      start = 1'b0;
      case (mode)
        0:       drive = 1'b1;
        1:       drive = (cyc % 2 == 0);
        default: drive = ($urandom_range(99) >= 30);
      endcase
      in_valid = drive;
      if (drive) begin
        a_in = qa[idx];
        b_in = qb[idx];
        if (in_ready) idx++;
      end
      cyc++;
    end
    check({tag, "_issued"}, idx, n);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    cyc = 0;
    while (!res_valid && cyc < 40) begin
      if (dsp_ce) lat++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, lat, PIPE_LAT);
    check({tag, "_ce_total"}, ce_total - ce0, n + PIPE_LAT);
    n01 = 0;
    n09 = 0;
    for (int i = o0; i < opm_seen.size(); i++) begin
      if (opm_seen[i] == 8'h01) n01++;
      if (opm_seen[i] == 8'h09) n09++;
    end
    check({tag, "_opm01_count"}, n01, 1);
    check({tag, "_opm09_count"}, n09, n - 1);
    if (o0 < opm_seen.size()) check({tag, "_opm_first"}, opm_seen[o0], 8'h01);
    check({tag, "_res_valid"}, res_valid, 1);
    check({tag, "_res_data"}, res_data, exp);
    check({tag, "_busy_hold"}, busy, 1);
    for (int i = 0; i < rdy_dly; i++) begin
      if (poke) begin
        start = 1'b1;
        len   = LEN_W'(3);
      end
      @(negedge clk);
      check({tag, "_bp_valid"}, res_valid, 1);
      check({tag, "_bp_data"}, res_data, exp);
      check({tag, "_bp_busy"}, busy, 1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    check({tag, "_valid_drop"}, res_valid, 0);
    check({tag, "_idle_busy"}, busy, 0);
    if (poke) begin
      @(negedge clk);
      check({tag, "_start_ignored"}, busy, 0);
    end
  endtask

  typedef struct {
    int          n;
    int          a[5];
    int          b[5];
    int          mode;
    int          rdy;
    bit          poke;
    logic [47:0] exp;
  } vec_t;

  vec_t vt [4];

  initial begin
    logic [47:0] e;
    vt[0].n = 3; vt[0].a = '{2, 4, -1, 0, 0}; vt[0].b = '{3, 5, 7, 0, 0};
    vt[0].mode = 0; vt[0].rdy = 0; vt[0].poke = 0; vt[0].exp = 48'd19;
    vt[1].n = 4; vt[1].a = '{1, 2, 3, 4, 0}; vt[1].b = '{1, 2, 3, 4, 0};
    vt[1].mode = 1; vt[1].rdy = 0; vt[1].poke = 0; vt[1].exp = 48'd30;
    vt[2].n = 3; vt[2].a = '{2, 4, -1, 0, 0}; vt[2].b = '{3, 5, 7, 0, 0};
    vt[2].mode = 0; vt[2].rdy = 10; vt[2].poke = 1; vt[2].exp = 48'd19;
    vt[3].n = 1; vt[3].a = '{-131072, 0, 0, 0, 0}; vt[3].b = '{-131072, 0, 0, 0, 0};
    vt[3].mode = 0; vt[3].rdy = 0; vt[3].poke = 0; vt[3].exp = 48'd17179869184;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_ce", dsp_ce, 0);
    check("rst_rstp", dsp_rstp, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_opmode", dsp_opmode, 0);
    check("rst_res_data", res_data, 0);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      qa.delete();
      qb.delete();
      for (int i = 0; i < vt[k].n; i++) begin
        qa.push_back(18'(vt[k].a[i]));
        qb.push_back(18'(vt[k].b[i]));
      end
      run_job(vt[k].n, vt[k].mode, vt[k].rdy, vt[k].poke, vt[k].exp, $sformatf("vec%0d", k));
    end

    begin : zero_len
      int ce0;
      ce0 = ce_total;
      @(negedge clk);
      start = 1'b1;
      len   = '0;
      @(negedge clk);
      start = 1'b0;
      check("zero_valid", res_valid, 1);
      check("zero_data", res_data, 0);
      check("zero_busy", busy, 1);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("zero_valid_drop", res_valid, 0);
      check("zero_ce", ce_total - ce0, 0);
    end

    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(5);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    a_in = 18'd9;
    b_in = 18'd9;
    @(negedge clk);
    a_in = 18'd10;
    b_in = 18'd10;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_ce", dsp_ce, 0);
    check("mid_rst_rstp", dsp_rstp, 1);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_dsp_a", dsp_a, 0);
    check("mid_rst_dsp_b", dsp_b, 0);
    check("mid_rst_opmode", dsp_opmode, 0);
    check("mid_rst_res_data", res_data, 0);
    rst = 1'b0;
    qa = '{18'd5, 18'd6};
    qb = '{18'd5, 18'd6};
    run_job(2, 0, 0, 0, 48'd61, "after_rst");

    qa.delete();
    qb.delete();
    for (int i = 0; i < 255; i++) begin
      qa.push_back(18'd131071);
      qb.push_back(18'd131071);
    end
    e = 48'(64'd255 * 64'd131071 * 64'd131071);
    run_job(255, 0, 0, 0, e, "max_len");

    for (int k = 0; k < 10; k++) begin
      int n;
      n = $urandom_range(1, 20);
      qa.delete();
      qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(18'($urandom));
        qb.push_back(18'($urandom));
      end
      run_job(n, 2, $urandom_range(0, 3), 0, ref_dot(), $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
